// File: rtl/gray_expand_pkg.sv
// gray_expand_pkg: shared image parameters for the sobel pipeline blocks
package gray_expand_pkg;
    localparam int IMG_DWIDTH_IN = 8;
    localparam int IMG_DWIDTH_OUT = 3 * IMG_DWIDTH_IN;
    localparam int IMG_WIDTH = 720;
    localparam int IMG_HEIGHT = 540;
    function automatic int cnt_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gray_expand_if.sv
// gray_expand_if: input/output FIFO handshake and frame pulse of gray_expand
interface gray_expand_if
    import gray_expand_pkg::*;
#(
    parameter int DWIDTH_IN = IMG_DWIDTH_IN,
    parameter int DWIDTH_OUT = IMG_DWIDTH_OUT
) ();
    logic fifo_in_rd_en;
    logic [DWIDTH_IN-1:0] fifo_in_dout;
    logic fifo_in_empty;
    logic fifo_out_wr_en;
    logic [DWIDTH_OUT-1:0] fifo_out_din;
    logic fifo_out_full;
    logic frame_done;
    modport master (
        output fifo_in_rd_en, fifo_out_wr_en, fifo_out_din, frame_done,
        input fifo_in_dout, fifo_in_empty, fifo_out_full
    );
    modport slave (
        input fifo_in_rd_en, fifo_out_wr_en, fifo_out_din, frame_done,
        output fifo_in_dout, fifo_in_empty, fifo_out_full
    );
endinterface

// File: rtl/gray_expand_buf.sv
// gray_expand_buf: 2-entry in-order holding buffer; caller never pushes when full or pops when empty
module gray_expand_buf #(
    parameter int W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] data,
    output logic [W-1:0] head,
    output logic [1:0] count
);
    logic [W-1:0] mem [2];
    logic rd_ptr, wr_ptr;
    assign head = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/gray_expand.sv
// gray_expand: replicates each gray pixel into {g,g,g} RGB with frame position tracking
module gray_expand
    import gray_expand_pkg::*;
#(
    parameter int DWIDTH_IN = IMG_DWIDTH_IN,
    parameter int DWIDTH_OUT = IMG_DWIDTH_OUT,
    parameter int WIDTH = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input logic clock,
    input logic reset,
    gray_expand_if.master bus
);
    localparam int CW = cnt_bits(WIDTH);
    localparam int RW = cnt_bits(HEIGHT);
    logic [DWIDTH_IN-1:0] head;
    logic [1:0] count;
    logic rd, wr, last_col, last_row, done;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    assign rd = !reset && !bus.fifo_in_empty && count < 2'd2;
    assign wr = !reset && count != 2'd0 && !bus.fifo_out_full;
    assign last_col = col == CW'(WIDTH - 1);
    assign last_row = row == RW'(HEIGHT - 1);
    assign bus.fifo_in_rd_en = rd;
    assign bus.fifo_out_wr_en = wr;
    assign bus.fifo_out_din = DWIDTH_OUT'({3{head}});
    assign bus.frame_done = done;
    gray_expand_buf #(.W(DWIDTH_IN)) u_buf (
        .clock(clock),
        .reset(reset),
        .push(rd),
        .pop(wr),
        .data(bus.fifo_in_dout),
        .head(head),
        .count(count)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            done <= 1'b0;
        end else begin
            done <= wr && last_col && last_row;
            if (wr) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gray_expand.sv
// tb_gray_expand: queue-based model of gray_expand with directed, table and random traffic
module tb_gray_expand;
    localparam int W = 4, H = 2, FRAME = W * H;
    typedef struct { logic [7:0] gray; logic [23:0] rgb; } vec_t;
    logic clock = 1'b0, reset = 1'b1;
    int checks = 0, failures = 0, cyc = 0;
    int n_rd = 0, n_wr = 0, n_fd = 0, written = 0;
    int last_rd_cyc = -1, last_wr_cyc = -1, last_fd_cyc = -1, frame_wr_cyc = -1;
    bit fd_pending = 0;
    logic [23:0] last_din = '0;
    logic [7:0] in_q[$];
    logic [23:0] exp_q[$];
    vec_t tbl[5];
    gray_expand_if bus ();
    gray_expand #(.WIDTH(W), .HEIGHT(H)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // One clock: expected rd/wr derived from input availability and model occupancy
    task automatic cycle(input bit hold, input bit full);
        bit erd, ewr, rd;
        logic [7:0] g;
        bus.fifo_in_empty = hold || in_q.size() == 0;
        bus.fifo_in_dout = bus.fifo_in_empty ? 8'hEE : in_q[0];
        bus.fifo_out_full = full;
        @(negedge clock);
        erd = !bus.fifo_in_empty && exp_q.size() < 2;
        ewr = exp_q.size() > 0 && !full;
        chk("rd_en", {31'd0, bus.fifo_in_rd_en}, {31'd0, erd});
        chk("wr_en", {31'd0, bus.fifo_out_wr_en}, {31'd0, ewr});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, fd_pending});
        if (bus.frame_done) begin
            n_fd++;
            last_fd_cyc = cyc;
        end
        fd_pending = 0;
        if (bus.fifo_out_wr_en) begin
            last_din = bus.fifo_out_din;
            last_wr_cyc = cyc;
            n_wr++;
            if (exp_q.size() > 0) begin
                chk("write_data", {8'd0, bus.fifo_out_din}, {8'd0, exp_q.pop_front()});
                written++;
                fd_pending = written % FRAME == 0;
                if (fd_pending) frame_wr_cyc = cyc;
            end
        end
        rd = bus.fifo_in_rd_en && !bus.fifo_in_empty;
        if (rd) begin
            last_rd_cyc = cyc;
            n_rd++;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (rd) begin
            g = in_q.pop_front();
            exp_q.push_back({g, g, g});
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.fifo_in_empty = 1'b0;
        bus.fifo_in_dout = 8'hA5;
        bus.fifo_out_full = 1'b0;
        @(negedge clock);
        chk("reset_rd_en", {31'd0, bus.fifo_in_rd_en}, 32'd0);
        chk("reset_wr_en", {31'd0, bus.fifo_out_wr_en}, 32'd0);
        @(posedge clock);
        #1;
        cyc++;
        chk("reset_frame_done", {31'd0, bus.frame_done}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        written = 0;
        fd_pending = 0;
    endtask
    task automatic drain(input bit rnd, input int budget);
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            if (rnd) cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            else cycle(0, 0);
            n++;
        end
        chk("drain_left", in_q.size() + exp_q.size(), 32'd0);
    endtask
    initial begin
        int r0, w0, f0, start;
        tbl[0] = '{8'h00, 24'h000000};
        tbl[1] = '{8'hFF, 24'hFFFFFF};
        tbl[2] = '{8'h80, 24'h808080};
        tbl[3] = '{8'h01, 24'h010101};
        tbl[4] = '{8'hC3, 24'hC3C3C3};
        do_reset();
        in_q.push_back(8'h5A);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        chk("single_din", {8'd0, last_din}, 32'h5A5A5A);
        chk("single_latency", last_wr_cyc - last_rd_cyc, 32'd1);
        for (int i = 0; i < 5; i++) begin
            w0 = n_wr;
            in_q.push_back(tbl[i].gray);
            for (int k = 0; k < 3; k++) cycle(0, 0);
            chk("table_writes", n_wr - w0, 32'd1);
            chk("table_din", {8'd0, last_din}, {8'd0, tbl[i].rgb});
        end
        w0 = n_wr;
        start = cyc;
        for (int i = 0; i < 16; i++) in_q.push_back(8'(i));
        for (int i = 0; i < 18; i++) cycle(0, 0);
        chk("stream_writes", n_wr - w0, 32'd16);
        chk("stream_last_cycle", last_wr_cyc - start, 32'd16);
        for (int i = 0; i < 20; i++) in_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 5; i++) cycle(0, 0);
        r0 = n_rd;
        w0 = n_wr;
        for (int i = 0; i < 10; i++) cycle(0, 1);
        chk("stall_pops_le2", {31'd0, (n_rd - r0) <= 2}, 32'd1);
        chk("stall_writes", n_wr - w0, 32'd0);
        drain(0, 100);
        do_reset();
        f0 = n_fd;
        for (int i = 0; i < 9; i++) in_q.push_back(8'(8'h90 + i));
        drain(0, 50);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        chk("frame_pulses", n_fd - f0, 32'd1);
        chk("frame_pulse_cycle", last_fd_cyc - frame_wr_cyc, 32'd1);
        for (int i = 0; i < 7; i++) in_q.push_back(8'(8'hB0 + i));
        drain(0, 50);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        chk("frame2_pulses", n_fd - f0, 32'd2);
        for (int i = 0; i < 4; i++) in_q.push_back(8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) cycle(0, 1);
        chk("pre_reset_occupancy", exp_q.size(), 32'd2);
        do_reset();
        w0 = n_wr;
        f0 = n_fd;
        for (int i = 0; i < 5; i++) cycle(1, 0);
        chk("post_reset_writes", n_wr - w0, 32'd0);
        chk("post_reset_frame_done", n_fd - f0, 32'd0);
        drain(0, 50);
        chk("post_reset_din", {8'd0, last_din}, 32'hC3C3C3);
        do_reset();
        for (int i = 0; i < 1000; i++) in_q.push_back(8'($urandom));
        w0 = n_wr;
        drain(1, 20000);
        chk("random_writes", n_wr - w0, 32'd1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gray_expand.md
GRAY_EXPAND -- requirements
Module: gray_expand

Interface
REQ-001 SHALL have parameter DWIDTH_IN, default 8, input gray pixel width.
REQ-002 SHALL have parameter DWIDTH_OUT, default 24, output RGB pixel width (3 x DWIDTH_IN).
REQ-003 SHALL have parameter WIDTH, default 720, pixels per line.
REQ-004 SHALL have parameter HEIGHT, default 540, lines per frame.
REQ-005 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port fifo_in_rd_en  output  1  pops input FIFO this cycle.
REQ-008 SHALL have port fifo_in_dout  input  DWIDTH_IN  gray pixel, first-word-fall-through, valid while not empty.
REQ-009 SHALL have port fifo_in_empty  input  1  input FIFO empty.
REQ-010 SHALL have port fifo_out_wr_en  output  1  pushes fifo_out_din this cycle.
REQ-011 SHALL have port fifo_out_din  output  DWIDTH_OUT  RGB pixel {R,G,B}.
REQ-012 SHALL have port fifo_out_full  input  1  output FIFO full.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.

Function
REQ-014 SHALL expand each gray value g to {g,g,g}, g in bits [23:16], [15:8] and [7:0], with no rounding or scaling.
REQ-015 SHALL hold pixels in a 2-entry in-order holding buffer with occupancy count 0..2.
REQ-016 SHALL assert fifo_in_rd_en combinationally iff fifo_in_empty=0 and count<2.
REQ-017 SHALL capture fifo_in_dout into the buffer tail on the rising edge on which fifo_in_rd_en=1.
REQ-018 SHALL assert fifo_out_wr_en combinationally iff count>0 and fifo_out_full=0, with fifo_out_din driven from the buffer head.
REQ-019 SHALL never assert fifo_out_wr_en while fifo_out_full=1; head data SHALL be held stable until written.
REQ-020 SHALL give a latency of 1 cycle: a pixel popped in cycle N is presented with fifo_out_wr_en at the earliest in cycle N+1.
REQ-021 SHALL sustain 1 pixel/cycle when input is non-empty and output is non-full; simultaneous read and write SHALL leave count unchanged.
REQ-022 SHALL keep column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), advanced only on writes.
REQ-023 SHALL wrap col to 0 and increment row on a write at col=WIDTH-1.
REQ-024 SHALL wrap col and row to 0 on a write at col=WIDTH-1 and row=HEIGHT-1, and assert frame_done for exactly the following cycle.
REQ-025 SHALL neither lose nor duplicate pixels under any interleaving of empty and full; a full-stall with count=2 SHALL block reads.

Reset
REQ-026 SHALL on reset=1 at a clock edge clear count, col, row, frame_done and buffer contents to 0.
REQ-027 SHALL hold fifo_in_rd_en=0 and fifo_out_wr_en=0 while reset=1, regardless of FIFO flags.
REQ-028 SHALL discard buffered pixels on reset mid-operation; the next frame starts at col=0, row=0.

Structure
REQ-029 SHALL take DWIDTH defaults and WIDTH/HEIGHT from the shared image-parameter package used by the sobel pipeline blocks.
REQ-030 SHALL implement the 2-entry buffer as sub-module gray_expand_buf (push/pop/head/count); counters and the frame_done logic SHALL stay in gray_expand.

Verification
REQ-031 SHALL verify single pixel: push 0x5A into an idle block with output not full -> fifo_out_din=0x5A5A5A with wr_en one cycle after rd_en.
REQ-032 SHALL verify streaming: 16 back-to-back pixels 0x00..0x0F with output never full -> 16 writes on consecutive cycles, in order, each {g,g,g}.
REQ-033 SHALL verify backpressure: full=1 for 10 cycles mid-stream -> at most 2 pops during the stall, no writes, output order preserved afterwards.
REQ-034 SHALL verify framing: WIDTH=4, HEIGHT=2, 8 pixels -> frame_done pulses once, one cycle after the 8th write; counters at 0; a 9th pixel is treated as col 0 of the next frame.
REQ-035 SHALL verify reset mid-stream: assert reset with count=2 -> no wr_en until new input arrives, discarded pixels never appear, frame_done stays 0.
REQ-036 SHALL verify random empty/full: random toggling over 1000 pixels -> scoreboard match with no wr_en while full and no rd_en while empty.
